// File: rtl/m_fetch.sv
// m_fetch: instruction-fetch stage holding IP, program memory and IR for the controller
module m_fetch #(
  parameter int ADDR_W     = 4,
  parameter int PROG_DEPTH = 16,
  parameter int INSTR_W    = 2 + ADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               next,
  input  logic               set,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [1:0]         com,
  output logic [ADDR_W-1:0]  target,
  output logic [ADDR_W-1:0]  ip,
  output logic               valid,
  output logic               fault
);
  typedef enum logic {FIRST, RUN} state_t;
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PROG_DEPTH - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0]  ip_q, ip_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d, fault_q, fault_d;
  logic [INSTR_W-1:0] mem [PROG_DEPTH];
  logic               go, run, in_rng, jump, step, fetch, wr;
  // state register plus the datapath registers it sequences
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FIRST;
      ip_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end
  // leave FIRST on the first controller pulse, RUN is absorbing until reset
  always_comb begin
    state_d = state_q;
    if (state_q == FIRST && (next || set)) state_d = RUN;
  end
  // next IP doubles as the memory read address; a same-address write bypasses into IR
  always_comb begin
    go      = state_q == FIRST && (next || set);
    run     = state_q == RUN;
    in_rng  = {1'b0, ir_q[ADDR_W-1:0]} < DEPTH;
    jump    = run && set && in_rng;
    step    = run && next && !set;
    fetch   = go || jump || step;
    wr      = load_en && {1'b0, load_addr} < DEPTH;
    ip_d    = go ? '0 : jump ? ir_q[ADDR_W-1:0] : step ? (ip_q == LAST ? '0 : ip_q + ADDR_W'(1)) : ip_q;
    ir_d    = !fetch ? ir_q : (wr && load_addr == ip_d) ? load_data : mem[ip_d];
    valid_d = valid_q || go;
    fault_d = fault_q || (run && set && !in_rng) || (step && ip_q == LAST);
  end
  // program memory load port, ignored while reset is asserted
  always_ff @(posedge clock) begin
    if (reset && wr) mem[load_addr] <= load_data;
  end
  assign com    = ir_q[INSTR_W-1 -: 2];
  assign target = ir_q[ADDR_W-1:0];
  assign ip     = ip_q;
  assign valid  = valid_q;
  assign fault  = fault_q;
endmodule

// File: doc/m_fetch.md
Name: m_fetch

Overview:
- Instruction-fetch stage directly upstream of the processor controller.
- Holds the instruction pointer (IP), a loadable program memory and the instruction register (IR).
- Presents the current opcode (com) and branch target to the controller.
- Advances on the controller's next pulse; jumps on its set pulse.

Parameters:
ADDR_W, 4, IP / branch-target width.
PROG_DEPTH, 16, program words implemented; must be <= 2**ADDR_W.
INSTR_W, 6, instruction width = 2 (opcode) + ADDR_W (target); fixed relation, not free.

Ports:
clock  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-low reset (sampled on posedge clock; 0 = reset).
next  in  1  advance IP by one (controller ip_next).
set  in  1  load IP from current IR target field (controller ip_set).
load_en  in  1  program-memory write strobe.
load_addr  in  ADDR_W  program-memory write address.
load_data  in  INSTR_W  program-memory write data.
com  out  2  opcode = IR[INSTR_W-1 -: 2].
target  out  ADDR_W  branch target = IR[ADDR_W-1:0].
ip  out  ADDR_W  address of the instruction held in IR.
valid  out  1  IR holds a fetched instruction.
fault  out  1  sticky: IP wrap or out-of-range jump occurred.

Behaviour:
- Reset (reset==0 at posedge):
  - ip=0, IR=0 (so com=00, target=0), valid=0, fault=0, FSM=FIRST.
  - Program memory is not cleared.
  - Reset mid-operation aborts any pending step; load_en in the same cycle is ignored.
- FSM states:
  - FIRST: waiting for the first fetch.
  - RUN: normal operation.
- FIRST state:
  - next=1 or set=1: IR<=mem[0], ip stays 0, valid<=1, go to RUN. The first controller next therefore executes word 0, not word 1.
  - Otherwise: hold.
- RUN, set=1 (set has priority over next when both are 1):
  - target < PROG_DEPTH: ip<=target, IR<=mem[target].
  - target >= PROG_DEPTH: ip and IR unchanged, fault<=1.
- RUN, next=1, set=0:
  - ip==PROG_DEPTH-1: ip<=0, IR<=mem[0], fault<=1 (wrap).
  - Otherwise: ip<=ip+1, IR<=mem[ip+1].
- RUN, next=0, set=0: ip, IR and valid hold.
- Latency: 1 cycle. com, target and ip reflect the new instruction in the cycle immediately after the posedge that samples next or set. This meets the controller's decode two states later.
- Memory:
  - PROG_DEPTH x INSTR_W, synchronous read; the read address is the next-IP value computed combinationally this cycle.
  - Write on posedge when load_en=1 and load_addr < PROG_DEPTH; an out-of-range write is dropped (no fault).
  - Write and fetch to the same address in the same cycle: IR receives load_data (write-first).
  - A write to the address currently held in IR does not update IR until the next fetch of that address.
- fault is cleared only by reset; operation continues after a fault.
- next/set held high for several cycles each act once per cycle; no edge detection.
- valid stays 1 from the first fetch until reset.

Test Plan:
- Reset, then load mem[0]=6'b00_0000, mem[1]=6'b01_0000, mem[2]=6'b10_0001. First next -> next cycle com=00, ip=0, valid=1. Second next -> com=01, ip=1. Third next -> com=10, target=1, ip=2.
- From ip=2 (IR=10_0001), pulse set -> next cycle ip=1, com=01. Then pulse next -> ip=2, com=10 (branch loop).
- In RUN at ip=3, assert next and set together with target=5 -> ip=5, IR=mem[5], not ip=4.
- Set PROG_DEPTH=12 and run next to ip=11, then next -> ip=0, com=mem[0] opcode, fault=1. fault stays 1 through further next/set until reset.
- With PROG_DEPTH=12 and IR target=14, pulse set -> ip and com unchanged, fault=1. Write mem[4] while next fetches ip 3->4 in the same cycle -> IR=new load_data.
- Mid-run at ip=7 with next=1, drive reset=0 for one cycle -> ip=0, com=00, valid=0, fault=0. Next pulse afterwards fetches mem[0] with ip staying 0.
